// File: rtl/ring_valid_buffer_pkg.sv
// Shared definitions for the ring buffer: overwrite-mode constants, default depth
// and a constant-evaluable ceil(log2) helper.
package ring_pkg;

    localparam int DEFAULT_WIDTH = 6;
    localparam int DEPTH         = 2 ** DEFAULT_WIDTH;

    localparam int OVR_BLOCK  = 0;
    localparam int OVR_OLDEST = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ring_valid_buffer_if.sv
// Producer/consumer bundle of the ring buffer. The buffer takes the slave side;
// whatever drives requests takes the master side.
interface ring_valid_buffer_if #(
    parameter int WIDTH  = 6,
    parameter int DWIDTH = 2 ** WIDTH
);
    logic              inc_y;
    logic [DWIDTH-1:0] wr_data;
    logic              wr_ack;
    logic              inc_x;
    logic              rd_valid;
    logic [DWIDTH-1:0] rd_data;
    logic [WIDTH:0]    count;
    logic              full;
    logic              empty;
    logic              overflow;

    modport master (
        output inc_y, wr_data, inc_x,
        input  wr_ack, rd_valid, rd_data, count, full, empty, overflow
    );

    modport slave (
        input  inc_y, wr_data, inc_x,
        output wr_ack, rd_valid, rd_data, count, full, empty, overflow
    );
endinterface

// File: rtl/ring_valid_buffer_ptr.sv
// WIDTH-bit wrap-around pointer: advances by one when en is high and wraps
// DEPTH-1 -> 0 through natural overflow. Synchronous reset has priority.
module ring_ptr #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] ptr
);
    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;

    // Next pointer value
    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = ptr_q + WIDTH'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/ring_valid_buffer.sv
// Circular buffer with per-entry valid bits, occupancy count, full/empty flags,
// sticky overflow, optional overwrite-oldest and one-hot self-test data.
module ring_valid_buffer
    import ring_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DWIDTH    = 2 ** WIDTH,
    parameter int OVERWRITE = OVR_BLOCK,
    parameter int SELF_TEST = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    ring_valid_buffer_if.slave    bus
);
    localparam int             N_ENTRIES = 2 ** WIDTH;
    localparam logic [WIDTH:0] FULL_CNT  = {1'b1, {WIDTH{1'b0}}};

    logic [WIDTH-1:0]     rd_ptr_s;
    logic [WIDTH-1:0]     wr_ptr_s;
    logic [DWIDTH-1:0]    mem_q [N_ENTRIES];
    logic [N_ENTRIES-1:0] valid_q, valid_d;
    logic [WIDTH:0]       count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 overflow_q, overflow_d;
    logic                 rd_fire_s, wr_fire_s, drop_s, rd_adv_s;
    logic [DWIDTH-1:0]    wr_word_s;

    // Accept decisions; full is registered state so a same-cycle read never makes room
    always_comb begin
        rd_fire_s = bus.inc_x & valid_q[rd_ptr_s];
        if (OVERWRITE == OVR_OLDEST) begin
            wr_fire_s = bus.inc_y;
        end else begin
            wr_fire_s = bus.inc_y & ~full_q;
        end
        drop_s    = wr_fire_s & full_q & ~rd_fire_s;
        rd_adv_s  = rd_fire_s | drop_s;
        if (SELF_TEST != 0) begin
            wr_word_s = {{(DWIDTH-1){1'b0}}, 1'b1} << wr_ptr_s;
        end else begin
            wr_word_s = bus.wr_data;
        end
    end

    // Next valid vector, count and flags; the clear precedes the set so a
    // same-index overwrite leaves the entry valid
    always_comb begin
        valid_d = valid_q;
        if (rd_adv_s) begin
            valid_d[rd_ptr_s] = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (wr_fire_s) begin
            valid_d[wr_ptr_s] = 1'b1;
        end else begin
            valid_d = valid_d;
        end
        if (wr_fire_s && !rd_fire_s && !full_q) begin
            count_d = count_q + {{WIDTH{1'b0}}, 1'b1};
        end else if (rd_fire_s && !wr_fire_s) begin
            count_d = count_q - {{WIDTH{1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
        full_d     = (count_d == FULL_CNT);
        empty_d    = (count_d == '0);
        overflow_d = overflow_q | (bus.inc_y & full_q);
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage, deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_q[wr_ptr_s] <= wr_word_s;
        end
    end

    ring_ptr #(.WIDTH(WIDTH)) u_rd_ptr (.clk(clk), .rst(rst), .en(rd_adv_s),  .ptr(rd_ptr_s));
    ring_ptr #(.WIDTH(WIDTH)) u_wr_ptr (.clk(clk), .rst(rst), .en(wr_fire_s), .ptr(wr_ptr_s));

    assign bus.wr_ack   = wr_fire_s;
    assign bus.rd_valid = valid_q[rd_ptr_s];
    assign bus.rd_data  = mem_q[rd_ptr_s];
    assign bus.count    = count_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.overflow = overflow_q;

`ifdef FORMAL
    // Occupancy must always match the number of valid entries
    always_comb begin
        assert ($countones(valid_q) == int'(count_q));
    end
`endif
endmodule

// File: tb/tb_ring_valid_buffer.sv
// Directed bench: blocking (W=2), overwrite (W=2) and self-test (W=3) instances.
module tb_ring_valid_buffer;
    import ring_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    ring_valid_buffer_if #(.WIDTH(2), .DWIDTH(8)) b0 ();
    ring_valid_buffer_if #(.WIDTH(2), .DWIDTH(8)) b1 ();
    ring_valid_buffer_if #(.WIDTH(3), .DWIDTH(8)) b2 ();

    ring_valid_buffer #(.WIDTH(2), .DWIDTH(8), .OVERWRITE(OVR_BLOCK), .SELF_TEST(0))
        u_blk (.clk(clk), .rst(rst), .bus(b0));
    ring_valid_buffer #(.WIDTH(2), .DWIDTH(8), .OVERWRITE(OVR_OLDEST), .SELF_TEST(0))
        u_ovr (.clk(clk), .rst(rst), .bus(b1));
    ring_valid_buffer #(.WIDTH(3), .DWIDTH(8), .OVERWRITE(OVR_BLOCK), .SELF_TEST(1))
        u_st  (.clk(clk), .rst(rst), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        b0.inc_x = 1'b0; b0.inc_y = 1'b0; b0.wr_data = 8'h00;
        b1.inc_x = 1'b0; b1.inc_y = 1'b0; b1.wr_data = 8'h00;
        b2.inc_x = 1'b0; b2.inc_y = 1'b0; b2.wr_data = 8'h00;
    endtask

    task automatic do_reset;
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr0(input logic [7:0] d);
        b0.inc_y = 1'b1; b0.wr_data = d;
        tick();
        b0.inc_y = 1'b0;
    endtask

    task automatic wr1(input logic [7:0] d);
        b1.inc_y = 1'b1; b1.wr_data = d;
        tick();
        b1.inc_y = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        tests_run++; if (b0.rd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_valid got %b exp 0", b0.rd_valid); end
        tests_run++; if (b0.empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %b exp 1", b0.empty); end
        tests_run++; if (b0.full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %b exp 0", b0.full); end
        tests_run++; if (b0.count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", b0.count); end
        tests_run++; if (b0.wr_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_ack got %b exp 0", b0.wr_ack); end
        tests_run++; if (b2.empty !== 1'b1) begin tests_failed++; $display("FAIL reset_st_empty got %b exp 1", b2.empty); end
    endtask

    task automatic test_three_writes;
        do_reset();
        wr0(8'h0A); wr0(8'h0B); wr0(8'h0C);
        tests_run++; if (b0.count !== 3'd3) begin tests_failed++; $display("FAIL w3_count got %0d exp 3", b0.count); end
        tests_run++; if (b0.rd_data !== 8'h0A) begin tests_failed++; $display("FAIL w3_rd_data got %h exp 0a", b0.rd_data); end
        tests_run++; if (b0.rd_valid !== 1'b1) begin tests_failed++; $display("FAIL w3_rd_valid got %b exp 1", b0.rd_valid); end
        tests_run++; if (b0.empty !== 1'b0) begin tests_failed++; $display("FAIL w3_empty got %b exp 0", b0.empty); end
        tests_run++; if (b0.overflow !== 1'b0) begin tests_failed++; $display("FAIL w3_overflow got %b exp 0", b0.overflow); end
    endtask

    task automatic test_block_full;
        do_reset();
        wr0(8'h01); wr0(8'h02); wr0(8'h03); wr0(8'h04);
        tests_run++; if (b0.full !== 1'b1) begin tests_failed++; $display("FAIL blk_full_pre got %b exp 1", b0.full); end
        b0.inc_y = 1'b1; b0.wr_data = 8'h05;
        #1;
        tests_run++; if (b0.wr_ack !== 1'b0) begin tests_failed++; $display("FAIL blk_wr_ack got %b exp 0", b0.wr_ack); end
        tick();
        b0.inc_y = 1'b0;
        tests_run++; if (b0.overflow !== 1'b1) begin tests_failed++; $display("FAIL blk_overflow got %b exp 1", b0.overflow); end
        tests_run++; if (b0.count !== 3'd4) begin tests_failed++; $display("FAIL blk_count got %0d exp 4", b0.count); end
        tests_run++; if (b0.full !== 1'b1) begin tests_failed++; $display("FAIL blk_full got %b exp 1", b0.full); end
        tests_run++; if (b0.rd_data !== 8'h01) begin tests_failed++; $display("FAIL blk_head got %h exp 01", b0.rd_data); end
    endtask

    task automatic test_overwrite;
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h0E;
        do_reset();
        wr1(8'h11); wr1(8'h22); wr1(8'h33); wr1(8'h44);
        b1.inc_y = 1'b1; b1.wr_data = 8'h0E;
        #1;
        tests_run++; if (b1.wr_ack !== 1'b1) begin tests_failed++; $display("FAIL ovr_wr_ack got %b exp 1", b1.wr_ack); end
        tick();
        b1.inc_y = 1'b0;
        tests_run++; if (b1.count !== 3'd4) begin tests_failed++; $display("FAIL ovr_count got %0d exp 4", b1.count); end
        tests_run++; if (b1.overflow !== 1'b1) begin tests_failed++; $display("FAIL ovr_overflow got %b exp 1", b1.overflow); end
        for (int i = 0; i < 4; i++) begin
            b1.inc_x = 1'b1;
            #1;
            tests_run++; if (b1.rd_data !== exp_q[i] || b1.rd_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_drain%0d got %h/%b exp %h/1", i, b1.rd_data, b1.rd_valid, exp_q[i]); end
            tick();
        end
        b1.inc_x = 1'b0;
        tests_run++; if (b1.empty !== 1'b1 || b1.count !== 3'd0) begin tests_failed++; $display("FAIL ovr_empty got %b/%0d exp 1/0", b1.empty, b1.count); end
    endtask

    task automatic test_self_test;
        int         exp_rd;
        int         exp_cnt;
        logic [7:0] exp_d;
        do_reset();
        exp_rd  = 0;
        exp_cnt = 0;
        b2.inc_x = 1'b1; b2.inc_y = 1'b1; b2.wr_data = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            #1;
            exp_d = 8'd1 << exp_rd;
            if (exp_cnt == 0) begin
                tests_run++; if (b2.rd_valid !== 1'b0) begin tests_failed++; $display("FAIL st_rd_valid%0d got %b exp 0", i, b2.rd_valid); end
            end else begin
                tests_run++; if (b2.rd_valid !== 1'b1 || b2.rd_data !== exp_d) begin tests_failed++; $display("FAIL st_data%0d got %b/%h exp 1/%h", i, b2.rd_valid, b2.rd_data, exp_d); end
            end
            tests_run++; if (b2.count !== 4'(exp_cnt)) begin tests_failed++; $display("FAIL st_count%0d got %0d exp %0d", i, b2.count, exp_cnt); end
            if (exp_cnt > 0) exp_rd = (exp_rd + 1) % 8;
            exp_cnt = 1;
            tick();
        end
        idle_all();
    endtask

    task automatic test_simul_full;
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h11; exp_q[1] = 8'h12; exp_q[2] = 8'h13;
        do_reset();
        wr0(8'h10); wr0(8'h11); wr0(8'h12); wr0(8'h13);
        b0.inc_x = 1'b1; b0.inc_y = 1'b1; b0.wr_data = 8'h77;
        #1;
        tests_run++; if (b0.wr_ack !== 1'b0) begin tests_failed++; $display("FAIL sim_wr_ack got %b exp 0", b0.wr_ack); end
        tick();
        idle_all();
        tests_run++; if (b0.count !== 3'd3) begin tests_failed++; $display("FAIL sim_count got %0d exp 3", b0.count); end
        tests_run++; if (b0.full !== 1'b0) begin tests_failed++; $display("FAIL sim_full got %b exp 0", b0.full); end
        tests_run++; if (b0.overflow !== 1'b1) begin tests_failed++; $display("FAIL sim_overflow got %b exp 1", b0.overflow); end
        for (int i = 0; i < 3; i++) begin
            b0.inc_x = 1'b1;
            #1;
            tests_run++; if (b0.rd_data !== exp_q[i]) begin tests_failed++; $display("FAIL sim_drain%0d got %h exp %h", i, b0.rd_data, exp_q[i]); end
            tick();
        end
        b0.inc_x = 1'b0;
        tests_run++; if (b0.empty !== 1'b1) begin tests_failed++; $display("FAIL sim_empty got %b exp 1", b0.empty); end
    endtask

    task automatic test_midop_reset;
        do_reset();
        b2.inc_y = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        b2.inc_y = 1'b0;
        b2.inc_x = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        b2.inc_x = 1'b0;
        tests_run++; if (b2.count !== 4'd5 || b2.overflow !== 1'b1) begin tests_failed++; $display("FAIL mid_pre got %0d/%b exp 5/1", b2.count, b2.overflow); end
        rst = 1'b1; b2.inc_y = 1'b1; b2.inc_x = 1'b1;
        tick();
        rst = 1'b0;
        idle_all();
        tests_run++; if (b2.count !== 4'd0) begin tests_failed++; $display("FAIL mid_count got %0d exp 0", b2.count); end
        tests_run++; if (b2.empty !== 1'b1) begin tests_failed++; $display("FAIL mid_empty got %b exp 1", b2.empty); end
        tests_run++; if (b2.rd_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rd_valid got %b exp 0", b2.rd_valid); end
        tests_run++; if (b2.overflow !== 1'b0) begin tests_failed++; $display("FAIL mid_overflow got %b exp 0", b2.overflow); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        idle_all();
        tick();
        test_reset();
        test_three_writes();
        test_block_full();
        test_overwrite();
        test_self_test();
        test_simul_full();
        test_midop_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
